// File: rtl/pe_cfg_loader_if.sv
// Host word stream and PE configuration bus seen by pe_cfg_loader.
// A host word transfers on a rising clk edge where s_valid && s_ready are both high;
// s_data must stay stable while s_valid is high, and s_ready never depends on s_valid.
interface pe_cfg_loader_if #(
   parameter int DAT_WID = 16,
   parameter int ADR_WID = 11
);
   logic               s_valid;
   logic [DAT_WID-1:0] s_data;
   logic               s_ready;
   logic [DAT_WID-1:0] cfg_dat;
   logic [ADR_WID-1:0] cfg_adr;

   modport master (output s_valid, s_data, input s_ready, cfg_dat, cfg_adr);
   modport slave  (input s_valid, s_data, output s_ready, cfg_dat, cfg_adr);
endinterface

// File: rtl/pe_cfg_loader.sv
// Streams host words onto the PE config bus as a consecutive-address write burst.
// Optional PE_CFG_CHKSUM_EN adds a running modulo sum of the words driven in a burst.
module pe_cfg_loader #(
   parameter int DAT_WID = 16,
   parameter int ADR_WID = 11,
   parameter int CNT_WID = 8,
   parameter int HOLD    = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [ADR_WID-1:0] base_adr,
   input  logic [CNT_WID-1:0] len,
   input  logic               abort,
   pe_cfg_loader_if.slave     bus,
   output logic               busy,
   output logic               done,
   output logic               err,
`ifdef PE_CFG_CHKSUM_EN
   output logic [DAT_WID-1:0] chksum,
`endif
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DRIVE, S_GAP, S_DONE} state_t;

   localparam int EW = ((CNT_WID > ADR_WID) ? CNT_WID : ADR_WID) + 1;
   localparam logic [EW-1:0]      ADR_MAX   = {{(EW-ADR_WID){1'b0}}, {ADR_WID{1'b1}}};
   localparam logic [3:0]         HOLD_LAST = 4'(HOLD - 1);
   localparam logic [CNT_WID:0]   ONE_W     = 1;

   state_t               state_q, state_d;
   logic [ADR_WID-1:0]   base_q, base_d;
   logic [CNT_WID-1:0]   len_q, len_d;
   logic [CNT_WID-1:0]   idx_q, idx_d;
   logic [3:0]           hold_q, hold_d;
   logic                 s_ready_q, s_ready_d;
   logic [DAT_WID-1:0]   cfg_dat_q, cfg_dat_d;
   logic [ADR_WID-1:0]   cfg_adr_q, cfg_adr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
`ifdef PE_CFG_CHKSUM_EN
   logic [DAT_WID-1:0]   chksum_q, chksum_d;
`endif

   logic [EW-1:0]        last_adr;
   logic                 reject;
   logic                 hs;
   logic [CNT_WID:0]     idx_nxt;

   // Bounds check is done one bit wider so a burst running past the top address is caught.
   assign last_adr = EW'(base_adr) + EW'(len) - EW'(1);
   assign reject   = (len == '0) || (base_adr == '0) || (last_adr > ADR_MAX);
   assign hs       = (state_q == S_WAIT) && bus.s_valid && s_ready_q;
   assign idx_nxt  = {1'b0, idx_q} + ONE_W;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      cfg_dat_d = cfg_dat_q;
      err_d     = 1'b0;
`ifdef PE_CFG_CHKSUM_EN
      chksum_d  = chksum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (reject) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  base_d   = base_adr;
                  len_d    = len;
                  idx_d    = '0;
                  state_d  = S_WAIT;
`ifdef PE_CFG_CHKSUM_EN
                  chksum_d = '0;
`endif
               end
            end
         end
         S_WAIT: begin
            // Abort wins over a same-cycle handshake: the word is consumed and dropped.
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (hs) begin
               cfg_dat_d = bus.s_data;
               hold_d    = '0;
               state_d   = S_DRIVE;
`ifdef PE_CFG_CHKSUM_EN
               chksum_d  = chksum_q + bus.s_data;
`endif
            end
         end
         S_DRIVE: begin
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = S_GAP;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               idx_d   = idx_nxt[CNT_WID-1:0];
               state_d = (idx_nxt < {1'b0, len_q}) ? S_WAIT : S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so none follows an input combinationally.
      s_ready_d = (state_d == S_WAIT);
      busy_d    = (state_d == S_WAIT) || (state_d == S_DRIVE) || (state_d == S_GAP);
      done_d    = (state_d == S_DONE);
      cfg_adr_d = (state_d == S_DRIVE) ? (base_q + ADR_WID'(idx_q)) : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         s_ready_q <= 1'b0;
         cfg_dat_q <= '0;
         cfg_adr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef PE_CFG_CHKSUM_EN
         chksum_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         s_ready_q <= s_ready_d;
         cfg_dat_q <= cfg_dat_d;
         cfg_adr_q <= cfg_adr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
`ifdef PE_CFG_CHKSUM_EN
         chksum_q  <= chksum_d;
`endif
      end
   end

   assign bus.s_ready = s_ready_q;
   assign bus.cfg_dat = cfg_dat_q;
   assign bus.cfg_adr = cfg_adr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
`ifdef PE_CFG_CHKSUM_EN
   assign chksum      = chksum_q;
`endif
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Bench for pe_cfg_loader: vector table, abort/reset sequences and random bursts vs a write-list model.
// Build with PE_CFG_CHKSUM_EN defined to also check the checksum output.
module tb_pe_cfg_loader;
   localparam int DW = 16, AW = 11, CW = 8, HOLD = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_adr = '0;
   logic [CW-1:0] len = '0;
   logic          busy, done, err;
   logic [2:0]    dbg_state;
`ifdef PE_CFG_CHKSUM_EN
   logic [DW-1:0] chksum;
`endif

   pe_cfg_loader_if #(.DAT_WID(DW), .ADR_WID(AW)) bus ();

   pe_cfg_loader #(.DAT_WID(DW), .ADR_WID(AW), .CNT_WID(CW), .HOLD(HOLD)) dut (
      .clk(clk), .rstn(rstn), .start(start), .base_adr(base_adr), .len(len),
      .abort(abort), .bus(bus.slave), .busy(busy), .done(done), .err(err),
`ifdef PE_CFG_CHKSUM_EN
      .chksum(chksum),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // write record: {address, data, cycles held}
   logic [AW+DW+7:0] exp_q[$];
   logic [AW+DW+7:0] got_q[$];
   int               n_total = 0, n_pass = 0;
   int               proto_viol = 0;
   logic [DW-1:0]    chk_model = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Bus monitor: collapses cfg_adr into write runs and flags protocol breaches.
   initial begin
      logic [AW-1:0] run_adr;
      logic [DW-1:0] run_dat;
      logic [7:0]    run_n;
      logic          done_prev;
      run_adr = '0; run_dat = '0; run_n = '0; done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.s_ready && (!busy || bus.cfg_adr != '0)) proto_viol++;
         if (done && (busy || done_prev)) proto_viol++;
         if (err && !done) proto_viol++;
         if (!busy && bus.cfg_adr != '0) proto_viol++;
         done_prev = done;
         if (bus.cfg_adr != '0) begin
            if (run_n == 0) begin
               run_adr = bus.cfg_adr; run_dat = bus.cfg_dat; run_n = 8'd1;
            end else if (bus.cfg_adr != run_adr || bus.cfg_dat != run_dat) begin
               proto_viol++;
               got_q.push_back({run_adr, run_dat, run_n});
               run_adr = bus.cfg_adr; run_dat = bus.cfg_dat; run_n = 8'd1;
            end else begin
               run_n = run_n + 8'd1;
            end
         end else if (run_n != 0) begin
            got_q.push_back({run_adr, run_dat, run_n});
            run_n = '0;
         end
      end
   end

   function automatic bit is_rejected(input logic [AW-1:0] b, input logic [CW-1:0] l);
      return (l == 0) || (b == 0) || (int'(b) + int'(l) - 1 > (1 << AW) - 1);
   endfunction

   // n_full: writes expected to reach the bus (-1 = whole burst); abort_cyc -1 = no abort.
   task automatic run_burst(input logic [AW-1:0] b, input logic [CW-1:0] l, input logic [DW-1:0] d0,
                            input bit rnd, input int stall_max, input int abort_cyc, input int n_full,
                            output int done_cyc, output logic done_err);
      logic [DW-1:0] wd[$];
      int w, stall, rel, nexp, t0;
      bit rej;
      wd = {};
      for (int i = 0; i < int'(l); i++) wd.push_back(rnd ? DW'($urandom) : d0 + DW'(i));
      rej  = is_rejected(b, l);
      nexp = rej ? 0 : ((n_full < 0) ? int'(l) : n_full);
      exp_q = {};
      got_q = {};
      for (int i = 0; i < nexp; i++) exp_q.push_back({b + AW'(i), wd[i], 8'(HOLD)});
      if (!rej) begin
         chk_model = '0;
         for (int i = 0; i < nexp; i++) chk_model = chk_model + wd[i];
      end
      proto_viol = 0;
      done_cyc = -1;
      done_err = 1'b0;
      w = 0;
      stall = $urandom_range(0, stall_max);
      @(negedge clk);
      start = 1'b1; base_adr = b; len = l; t0 = cyc;
      for (int c = 0; c < 4000; c++) begin
         if (c > 0) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
               done_cyc = cyc - t0;
               done_err = err;
               break;
            end
         end
         rel = cyc - t0;
         abort = (rel == abort_cyc);
         if (stall > 0) begin
            bus.s_valid = 1'b0;
            stall--;
         end else if (w < int'(l)) begin
            bus.s_valid = 1'b1;
            bus.s_data  = wd[w];
         end else begin
            bus.s_valid = 1'b0;
         end
         if (bus.s_valid && bus.s_ready) begin
            w++;
            stall = $urandom_range(0, stall_max);
         end
      end
      abort = 1'b0; bus.s_valid = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_vec(input string name, input logic [AW-1:0] b, input logic [CW-1:0] l,
                         input logic [DW-1:0] d0, input bit rnd, input int stall_max,
                         input int abort_cyc, input int n_full, input logic exp_err, input int exp_done);
      int   done_cyc;
      logic done_err;
      int   nmin;
      run_burst(b, l, d0, rnd, stall_max, abort_cyc, n_full, done_cyc, done_err);
      chk({name, " done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
      chk({name, " err"}, done_err, exp_err);
      if (exp_done >= 0) chk({name, " done_cycle"}, done_cyc, exp_done);
      chk({name, " n_writes"}, got_q.size(), exp_q.size());
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) chk($sformatf("%s write%0d", name, i), got_q[i], exp_q[i]);
      chk({name, " protocol"}, proto_viol, 0);
`ifdef PE_CFG_CHKSUM_EN
      chk({name, " chksum"}, chksum, chk_model);
`endif
      chk({name, " idle_after"}, {busy, bus.s_ready, bus.cfg_adr}, 0);
   endtask

   typedef struct {
      logic [AW-1:0] b;
      logic [CW-1:0] l;
      logic [DW-1:0] d0;
      int            stall;
      logic          exp_err;
      int            exp_done;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cnt;
      logic [AW-1:0] rb;
      logic [CW-1:0] rl;
      int rs;
      bit rj;
      vecs[0] = '{11'h010, 8'd3, 16'hA001, 0, 1'b0, 13};
      vecs[1] = '{11'h123, 8'd0, 16'h1111, 0, 1'b1, 1};
      vecs[2] = '{11'h000, 8'd2, 16'h2222, 0, 1'b1, 1};
      vecs[3] = '{11'h7FF, 8'd2, 16'h3333, 0, 1'b1, 1};
      vecs[4] = '{11'h7FE, 8'd2, 16'h4444, 0, 1'b0, 9};
      vecs[5] = '{11'h010, 8'd3, 16'hA001, 5, 1'b0, -1};
      vecs[6] = '{11'h7FF, 8'd1, 16'h5555, 0, 1'b0, 5};
      vecs[7] = '{11'h700, 8'd8, 16'h6000, 2, 1'b0, -1};

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset s_ready", bus.s_ready, 0);
      chk("reset cfg_adr", bus.cfg_adr, 0);
      chk("reset cfg_dat", bus.cfg_dat, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
`ifdef PE_CFG_CHKSUM_EN
      chk("reset chksum", chksum, 0);
`endif
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         do_vec($sformatf("vec%0d", i), vecs[i].b, vecs[i].l, vecs[i].d0, 1'b0, vecs[i].stall,
                -1, -1, vecs[i].exp_err, vecs[i].exp_done);

      // abort in the second DRIVE cycle of word 2 of a 4-word burst
      do_vec("abort_drive", 11'h200, 8'd4, 16'hC000, 1'b0, 0, 7, 2, 1'b1, 8);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.s_ready) cnt++;
         bus.s_valid = 1'b1;
         bus.s_data  = 16'hFFFF;
      end
      bus.s_valid = 1'b0;
      chk("abort s_ready_low", cnt, 0);

      // abort coinciding with the first handshake: word dropped, nothing written
      do_vec("abort_hs", 11'h210, 8'd2, 16'hD000, 1'b0, 0, 1, 0, 1'b1, 2);

      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = AW'($urandom_range(1, 2047));
            2:       rb = AW'(2047 - $urandom_range(0, 5));
            default: rb = AW'($urandom_range(1, 64));
         endcase
         rl = CW'($urandom_range(0, 6));
         rs = $urandom_range(0, 5);
         rj = is_rejected(rb, rl);
         do_vec($sformatf("rnd%0d", i), rb, rl, 16'h0, 1'b1, rs, -1, -1, rj,
                rj ? 1 : ((rs == 0) ? 1 + int'(rl) * (HOLD + 2) : -1));
      end

      // asynchronous reset in the middle of a DRIVE
      @(negedge clk);
      start = 1'b1; base_adr = 11'h300; len = 8'd3;
      bus.s_valid = 1'b1; bus.s_data = 16'hBEEF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_reset cfg_adr", bus.cfg_adr, 11'h300);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("async_reset outputs", {bus.s_ready, busy, done, err}, 0);
      chk("async_reset cfg_adr", bus.cfg_adr, 0);
      chk("async_reset cfg_dat", bus.cfg_dat, 0);
`ifdef PE_CFG_CHKSUM_EN
      chk("async_reset chksum", chksum, 0);
`endif
      bus.s_valid = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      chk_model = '0;
      @(negedge clk);
      do_vec("after_reset", 11'h100, 8'd3, 16'h0001, 1'b0, 0, -1, -1, 1'b0, 13);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
